// File: rtl/note_recorder_pkg.sv
// Shared definitions for the note recorder: code widths, rest/idle codes
// and the controller state encoding.
package note_recorder_pkg;

  localparam int NOTE_W = 4;
  localparam int OCT_W  = 2;

  // Note code 0 is a rest; 1..7 are do..si.
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [OCT_W-1:0]  OCT_NONE  = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REC   = 2'd1,
    S_FETCH = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

endpackage

// File: rtl/note_recorder_if.sv
// Bundle of the recorder's live note input, command pulses and playback/status
// outputs. The controller side is the master, the recorder is the slave.
interface note_recorder_if #(
  parameter int DEPTH = 64
);
  import note_recorder_pkg::*;

  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic [NOTE_W-1:0] note_in;
  logic [OCT_W-1:0]  octave_in;
  logic              rec_start;
  logic              play_start;
  logic              stop;
  logic [NOTE_W-1:0] note_out;
  logic [OCT_W-1:0]  octave_out;
  logic              recording;
  logic              playing;
  logic              full;
  logic [LEN_W-1:0]  length;

  modport master (
    output note_in, octave_in, rec_start, play_start, stop,
    input  note_out, octave_out, recording, playing, full, length
  );

  modport slave (
    input  note_in, octave_in, rec_start, play_start, stop,
    output note_out, octave_out, recording, playing, full, length
  );

endinterface

// File: rtl/note_recorder_tick_gen.sv
// Duration tick generator: one-cycle pulse every TICK_CYCLES clocks.
// clr restarts the period so the first tick after clr lands exactly
// TICK_CYCLES clocks later; tick itself depends only on the count.
module note_recorder_tick_gen #(
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  // Free-running period counter, restarted by clr or on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/note_recorder.sv
// Free-play note recorder: captures {note, octave, duration} events into an
// inferred RAM while recording, and replays them on note_out/octave_out.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int TICK_CYCLES = 1_000_000,
  parameter int DUR_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  note_recorder_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int EV_W   = NOTE_W + OCT_W;
  localparam int WORD_W = EV_W + DUR_W;

  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  state_t            state_reg, state_next;
  logic [EV_W-1:0]   cur_reg, cur_next;
  logic [DUR_W-1:0]  dur_reg, dur_next;
  logic [DUR_W-1:0]  rem_reg, rem_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [NOTE_W-1:0] note_reg, note_next;
  logic [OCT_W-1:0]  oct_reg, oct_next;
  logic              full_reg, full_next;

  logic [EV_W-1:0]   live;
  logic [DUR_W-1:0]  dur_now;
  logic [LEN_W-1:0]  len_inc;
  logic [LEN_W-1:0]  addr_inc;
  logic              tick;
  logic              tick_clr;
  logic              we;
  logic              go_rec;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] rd_data_reg;

  logic [WORD_W-1:0] mem [DEPTH];

  note_recorder_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign live     = {bus.note_in, bus.octave_in};
  // Duration including this cycle's tick; never exceeds DUR_MAX because
  // reaching DUR_MAX forces a write and a restart from zero.
  assign dur_now  = dur_reg + DUR_W'(tick);
  assign len_inc  = len_reg + LEN_ONE;
  assign addr_inc = {1'b0, addr_reg} + LEN_ONE;
  assign wr_data  = {cur_reg, dur_now};

  // Next-state and datapath decode; command priority is stop > rec_start > play_start.
  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    dur_next   = dur_reg;
    rem_next   = rem_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    note_next  = note_reg;
    oct_next   = oct_reg;
    full_next  = full_reg;
    tick_clr   = 1'b0;
    we         = 1'b0;
    go_rec     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.stop) begin
          state_next = S_IDLE;
        end else if (bus.rec_start) begin
          go_rec = 1'b1;
        end else if (bus.play_start && (len_reg != '0)) begin
          state_next = S_FETCH;
          addr_next  = '0;
          tick_clr   = 1'b1;
        end
      end

      S_REC: begin
        if (bus.stop) begin
          // Flush the note in progress if it lasted at least one tick.
          we         = (dur_now != '0);
          state_next = S_IDLE;
        end else if (bus.rec_start) begin
          go_rec = 1'b1;
        end else begin
          if (live != cur_reg) begin
            // A change shorter than one tick is a glitch and is dropped.
            we       = (dur_now != '0);
            cur_next = live;
            dur_next = '0;
          end else if (tick && (dur_now == DUR_MAX)) begin
            // Long notes are split into DUR_MAX-sized events.
            we       = 1'b1;
            dur_next = '0;
          end else begin
            dur_next = dur_now;
          end
          if (we && (len_inc == LEN_FULL)) begin
            state_next = S_IDLE;
          end
        end
      end

      S_FETCH: begin
        if (bus.stop) begin
          state_next = S_IDLE;
          note_next  = NOTE_REST;
          oct_next   = OCT_NONE;
        end else if (bus.rec_start) begin
          go_rec    = 1'b1;
          note_next = NOTE_REST;
          oct_next  = OCT_NONE;
        end else begin
          // The word for addr was read on the edge that entered FETCH.
          state_next = S_PLAY;
          note_next  = rd_data_reg[WORD_W-1 -: NOTE_W];
          oct_next   = rd_data_reg[DUR_W +: OCT_W];
          rem_next   = rd_data_reg[DUR_W-1:0];
          tick_clr   = 1'b1;
        end
      end

      S_PLAY: begin
        if (bus.stop) begin
          state_next = S_IDLE;
          note_next  = NOTE_REST;
          oct_next   = OCT_NONE;
        end else if (bus.rec_start) begin
          go_rec    = 1'b1;
          note_next = NOTE_REST;
          oct_next  = OCT_NONE;
        end else if (tick) begin
          if (rem_reg <= DUR_ONE) begin
            if (addr_inc < len_reg) begin
              // note_out keeps the finished note through the FETCH cycle.
              state_next = S_FETCH;
              addr_next  = addr_reg + ADDR_W'(1);
              tick_clr   = 1'b1;
            end else begin
              state_next = S_IDLE;
              note_next  = NOTE_REST;
              oct_next   = OCT_NONE;
            end
          end else begin
            rem_next = rem_reg - DUR_ONE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (go_rec) begin
      state_next = S_REC;
      len_next   = '0;
      full_next  = 1'b0;
      cur_next   = live;
      dur_next   = '0;
      tick_clr   = 1'b1;
    end

    if (we) begin
      len_next = len_inc;
      if (len_inc == LEN_FULL) begin
        full_next = 1'b1;
      end
    end
  end

  // Controller and datapath registers; reset discards the recording.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cur_reg   <= '0;
      dur_reg   <= '0;
      rem_reg   <= '0;
      len_reg   <= '0;
      addr_reg  <= '0;
      note_reg  <= NOTE_REST;
      oct_reg   <= OCT_NONE;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      dur_reg   <= dur_next;
      rem_reg   <= rem_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      note_reg  <= note_next;
      oct_reg   <= oct_next;
      full_reg  <= full_next;
    end
  end

  // Event RAM: write at the current length, registered read of the next address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[len_reg[ADDR_W-1:0]] <= wr_data;
    end
    rd_data_reg <= mem[addr_next];
  end

  assign bus.note_out   = note_reg;
  assign bus.octave_out = oct_reg;
  assign bus.recording  = (state_reg == S_REC);
  assign bus.playing    = (state_reg == S_FETCH) || (state_reg == S_PLAY);
  assign bus.full       = full_reg;
  assign bus.length     = len_reg;

endmodule
